hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl_pkg.sv | 24 ++
 rtl/hazard_stall_ctrl_if.sv | 49 ++++
 rtl/hazard_stall_ctrl_sat_counter.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg : shared types and register-match helper for hazard_stall_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_e;

  // $0 is hardwired to zero, so it can never carry a dependency
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] rd);
    return (src != '0) && (src == rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if : pipeline-state inputs and stall/flush controls
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import hazard_pkg::*;

  logic [REG_W-1:0] IFID_Rs;
  logic [REG_W-1:0] IFID_Rt;
  logic             IFID_UsesRt;
  logic             ID_Branch;
  logic             branch_taken;
  logic             ID_Jump;
  logic             ID_MduOp;
  logic             IDEX_MemRead;
  logic             IDEX_RegWrite;
  logic [REG_W-1:0] IDEX_Rd;
  logic             EXMEM_MemRead;
  logic [REG_W-1:0] EXMEM_Rd;

  logic             PC_Write;
  logic             IFID_Write;
  logic             IF_flush;
  logic             ID_bubble;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, ID_Branch, branch_taken, ID_Jump,
           ID_MduOp, IDEX_MemRead, IDEX_RegWrite, IDEX_Rd, EXMEM_MemRead, EXMEM_Rd,
    input  PC_Write, IFID_Write, IF_flush, ID_bubble, mdu_busy,
           stall_count, flush_count
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, ID_Branch, branch_taken, ID_Jump,
           ID_MduOp, IDEX_MemRead, IDEX_RegWrite, IDEX_Rd, EXMEM_MemRead, EXMEM_Rd,
    output PC_Write, IFID_Write, IF_flush, ID_bubble, mdu_busy,
           stall_count, flush_count
  );

endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : event counter that saturates at all-ones
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl : load-use / branch-operand hazard detection and MDU stall FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int MCNT_W = $clog2(MDU_LAT + 1);

  state_e            state_q;
  state_e            state_d;
  logic [MCNT_W-1:0] cnt_q;
  logic [MCNT_W-1:0] cnt_d;

  logic match_ex;
  logic match_mem;
  logic hazard;
  logic pc_write;
  logic ifid_write;
  logic if_flush;
  logic id_bubble;
  logic mdu_busy;

  always_comb begin
    match_ex  = reg_match(bus.IFID_Rs, bus.IDEX_Rd) ||
                (bus.IFID_UsesRt && reg_match(bus.IFID_Rt, bus.IDEX_Rd));
    match_mem = reg_match(bus.IFID_Rs, bus.EXMEM_Rd) ||
                (bus.IFID_UsesRt && reg_match(bus.IFID_Rt, bus.EXMEM_Rd));
    hazard    = (bus.IDEX_MemRead && match_ex) ||
                (bus.ID_Branch && bus.IDEX_RegWrite && match_ex) ||
                (bus.ID_Branch && bus.EXMEM_MemRead && match_mem);
  end

  // Outputs are forced low while rst is held, independent of state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    if_flush   = 1'b0;
    id_bubble  = 1'b0;
    mdu_busy   = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            id_bubble = 1'b1;
          end else if (bus.ID_MduOp) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            state_d    = MDU_BUSY;
            cnt_d      = MCNT_W'(MDU_LAT - 1);
          end else if (bus.branch_taken || bus.ID_Jump) begin
            pc_write = 1'b1;
            if_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        MDU_BUSY: begin
          id_bubble = 1'b1;
          mdu_busy  = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - MCNT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PC_Write   = pc_write;
  assign bus.IFID_Write = ifid_write;
  assign bus.IF_flush   = if_flush;
  assign bus.ID_bubble  = id_bubble;
  assign bus.mdu_busy   = mdu_busy;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (id_bubble),
    .count (bus.stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_flush),
    .count (bus.flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl : directed checks of hazard_stall_ctrl (two configurations)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus1 ();
  hazard_stall_ctrl_if #(.CNT_W(2))  bus2 ();

  hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  hazard_stall_ctrl #(.MDU_LAT(1), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus1.IFID_Rs = '0; bus1.IFID_Rt = '0; bus1.IFID_UsesRt = 1'b0;
    bus1.ID_Branch = 1'b0; bus1.branch_taken = 1'b0; bus1.ID_Jump = 1'b0;
    bus1.ID_MduOp = 1'b0; bus1.IDEX_MemRead = 1'b0; bus1.IDEX_RegWrite = 1'b0;
    bus1.IDEX_Rd = '0; bus1.EXMEM_MemRead = 1'b0; bus1.EXMEM_Rd = '0;
    bus2.IFID_Rs = '0; bus2.IFID_Rt = '0; bus2.IFID_UsesRt = 1'b0;
    bus2.ID_Branch = 1'b0; bus2.branch_taken = 1'b0; bus2.ID_Jump = 1'b0;
    bus2.ID_MduOp = 1'b0; bus2.IDEX_MemRead = 1'b0; bus2.IDEX_RegWrite = 1'b0;
    bus2.IDEX_Rd = '0; bus2.EXMEM_MemRead = 1'b0; bus2.EXMEM_Rd = '0;
  endtask

  // pc, ifid, flush, bubble of the main instance in one go
  task automatic chk_ctl(input string tag, input logic pc, input logic ifid,
                         input logic fl, input logic bub);
    chk({tag, ".pc"},     32'(bus1.PC_Write),   32'(pc));
    chk({tag, ".ifid"},   32'(bus1.IFID_Write), 32'(ifid));
    chk({tag, ".flush"},  32'(bus1.IF_flush),   32'(fl));
    chk({tag, ".bubble"}, 32'(bus1.ID_bubble),  32'(bub));
  endtask

  initial begin
    // reset: outputs low even with a taken branch presented
    idle();
    rst = 1'b1;
    bus1.branch_taken = 1'b1;
    cyc();
    cyc();
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.busy",  32'(bus1.mdu_busy),    32'd0);
    chk("rst.stall", 32'(bus1.stall_count), 32'd0);
    chk("rst.flush_cnt", 32'(bus1.flush_count), 32'd0);

    rst = 1'b0;
    idle();
    #1;
    chk_ctl("run", 1'b1, 1'b1, 1'b0, 1'b0);

    // load-use on rs
    bus1.IDEX_MemRead = 1'b1; bus1.IDEX_Rd = 5'd8; bus1.IFID_Rs = 5'd8;
    #1;
    chk_ctl("lduse", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    idle();
    #1;
    chk("lduse.stall", 32'(bus1.stall_count), 32'd1);
    chk_ctl("lduse.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // load feeding a branch: two stalls then taken flush
    bus1.ID_Branch = 1'b1; bus1.IFID_Rs = 5'd9;
    bus1.IDEX_MemRead = 1'b1; bus1.IDEX_RegWrite = 1'b1; bus1.IDEX_Rd = 5'd9;
    bus1.branch_taken = 1'b1;
    #1;
    chk_ctl("ldbr1", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    bus1.IDEX_MemRead = 1'b0; bus1.IDEX_RegWrite = 1'b0; bus1.IDEX_Rd = '0;
    bus1.EXMEM_MemRead = 1'b1; bus1.EXMEM_Rd = 5'd9;
    #1;
    chk_ctl("ldbr2", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    bus1.EXMEM_MemRead = 1'b0; bus1.EXMEM_Rd = '0;
    #1;
    chk_ctl("ldbr3", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    chk("ldbr.stall", 32'(bus1.stall_count), 32'd3);
    chk("ldbr.flush", 32'(bus1.flush_count), 32'd1);

    // ALU result feeding a branch via rt: only counts when rt is read
    bus1.ID_Branch = 1'b1; bus1.IDEX_RegWrite = 1'b1; bus1.IDEX_Rd = 5'd5;
    bus1.IFID_Rt = 5'd5; bus1.IFID_UsesRt = 1'b0; bus1.IFID_Rs = 5'd3;
    #1;
    chk("brex.nort", 32'(bus1.ID_bubble), 32'd0);
    bus1.IFID_UsesRt = 1'b1;
    #1;
    chk_ctl("brex.rt", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    idle();
    #1;
    chk("brex.stall", 32'(bus1.stall_count), 32'd4);

    // jump masked by hazard, then flushes once hazard clears
    bus1.ID_Jump = 1'b1; bus1.IDEX_MemRead = 1'b1; bus1.IDEX_Rd = 5'd12; bus1.IFID_Rs = 5'd12;
    #1;
    chk_ctl("jmp.haz", 1'b0, 1'b0, 1'b0, 1'b1);
    bus1.IDEX_MemRead = 1'b0;
    #1;
    chk_ctl("jmp", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    chk("jmp.flush", 32'(bus1.flush_count), 32'd2);
    chk("jmp.stall", 32'(bus1.stall_count), 32'd4);

    // register $0 never hazards
    bus1.IDEX_MemRead = 1'b1; bus1.IDEX_Rd = 5'd0; bus1.IFID_Rs = 5'd0;
    bus1.IFID_Rt = 5'd0; bus1.IFID_UsesRt = 1'b1;
    #1;
    chk_ctl("r0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    idle();

    // MDU issue beats a taken branch, then 4 busy cycles
    bus1.ID_MduOp = 1'b1; bus1.branch_taken = 1'b1;
    #1;
    chk_ctl("mdu.issue", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mdu.issue.busy", 32'(bus1.mdu_busy), 32'd0);
    cyc();
    idle();
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        bus1.branch_taken = 1'b1;
        bus1.ID_Jump = 1'b1;
      end
      #1;
      chk($sformatf("mdu.busy%0d", i), 32'(bus1.mdu_busy), 32'd1);
      chk_ctl($sformatf("mdu.c%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      cyc();
      idle();
    end
    #1;
    chk("mdu.done", 32'(bus1.mdu_busy), 32'd0);
    chk_ctl("mdu.done", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mdu.stall", 32'(bus1.stall_count), 32'd8);
    chk("mdu.flush", 32'(bus1.flush_count), 32'd2);

    // reset during the second busy cycle aborts the stall
    bus1.ID_MduOp = 1'b1;
    cyc();
    idle();
    #1;
    chk("rmdu.b1", 32'(bus1.mdu_busy), 32'd1);
    cyc();
    #1;
    chk("rmdu.b2", 32'(bus1.mdu_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmdu.rst.busy", 32'(bus1.mdu_busy), 32'd0);
    chk_ctl("rmdu.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rmdu.run.busy", 32'(bus1.mdu_busy), 32'd0);
    chk_ctl("rmdu.run", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rmdu.stall", 32'(bus1.stall_count), 32'd0);
    chk("rmdu.flush", 32'(bus1.flush_count), 32'd0);

    // MDU_LAT=1 instance: exactly one busy cycle
    bus2.ID_MduOp = 1'b1;
    cyc();
    idle();
    #1;
    chk("lat1.b1", 32'(bus2.mdu_busy), 32'd1);
    chk("lat1.bub", 32'(bus2.ID_bubble), 32'd1);
    cyc();
    #1;
    chk("lat1.done", 32'(bus2.mdu_busy), 32'd0);
    chk("lat1.pc", 32'(bus2.PC_Write), 32'd1);
    chk("lat1.stall", 32'(bus2.stall_count), 32'd1);

    // CNT_W=2 saturation under a held load-use hazard
    bus2.IDEX_MemRead = 1'b1; bus2.IDEX_Rd = 5'd8; bus2.IFID_Rs = 5'd8;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk($sformatf("sat.%0d", i), 32'(bus2.stall_count), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
